// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : UART receiver (8N1) with one-entry valid/ready holding reg.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
// Revision: 1.0
// ============================================================================
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       usb_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       overrun_clr,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] c_full = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_idx, w_idx_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_sync1, r_rxs;
   logic [7:0]       r_data;
   logic             r_valid, r_ferr, r_ovr;
   logic             w_good, w_ferr, w_cnt_zero;
`ifdef UART_RX_PARITY_EN
   logic             r_par, w_par_nxt, r_perr, w_perr;
`endif

   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par;
      w_perr      = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!r_rxs) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = c_half;
            end
         end
         S_START: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - c_one;
            end else if (r_rxs) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = 3'd0;
               w_cnt_nxt   = c_full;
            end
         end
         S_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - c_one;
            end else begin
               // LSB arrives first, so shifting right leaves bit 0 at the bottom
               w_shift_nxt = {r_rxs, r_shift[7:1]};
               w_cnt_nxt   = c_full;
               w_idx_nxt   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - c_one;
            end else begin
               w_par_nxt   = r_rxs;
               w_cnt_nxt   = c_full;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - c_one;
            end else if (r_rxs) begin
               w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
               if ((^r_shift) == r_par) w_good = 1'b1;
               else                     w_perr = 1'b1;
`else
               w_good = 1'b1;
`endif
            end else begin
               w_state_nxt = S_WAIT_IDLE;
               w_ferr      = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (r_rxs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par   <= 1'b0;
         r_perr  <= 1'b0;
`endif
      end else begin
         r_sync1 <= usb_rx;
         r_rxs   <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
         r_par   <= w_par_nxt;
         r_perr  <= w_perr;
`endif
         if (w_good) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
         // a fresh overrun event beats a simultaneous clear
         if (w_good && r_valid && !rx_ready) r_ovr <= 1'b1;
         else if (overrun_clr)               r_ovr <= 1'b0;
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;
   assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire
